writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage: consumer end of the MEM/WB interface (memory_pkg::mem_wb_t).
//  - Selects the writeback result (load data vs ALU result).
//  - Owns the 32x32 integer register file.
//  - Serves ID's two read ports with write-through bypass.
//  - Publishes a registered commit trace and cycle/writeback counters for debug and perf.
// PARAMETERS
//  XLEN      32  datapath / register width
//  NUM_REGS  32  architectural registers; x0 hardwired to zero
//  CNT_W     64  width of cycle_count / wr_count
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  mem_wb       in   struct memory_pkg::mem_wb_t {mem_data, alu_result, rd, RegWrite, MemToReg}
//  rs1_addr     in   5      ID read port 1 address
//  rs2_addr     in   5      ID read port 2 address
//  rs1_data     out  XLEN   read port 1 data (combinational)
//  rs2_data     out  XLEN   read port 2 data (combinational)
//  wb_en        out  1      writeback active this cycle (forwarding-unit input)
//  wb_rd        out  5      writeback destination (forwarding-unit input)
//  wb_data      out  XLEN   writeback value (forwarding-unit input)
//  trace_valid  out  1      registered: a register write committed last cycle
//  trace_rd     out  5      registered: destination of that write
//  trace_data   out  XLEN   registered: value of that write
//  cycle_count  out  CNT_W  cycles since reset deasserted
//  wr_count     out  CNT_W  number of committed register writes
// BEHAVIOUR
//  - Result mux: wb_data = mem_wb.MemToReg ? mem_wb.mem_data : mem_wb.alu_result (combinational).
//  - Enable: wb_en = mem_wb.RegWrite && (mem_wb.rd != 0); wb_rd = mem_wb.rd.
//    - A MEM/WB bubble (all-zero struct) therefore never writes.
//  - Register file write: at posedge, if wb_en && !reset, regs[wb_rd] <= wb_data.
//    - Writes to x0 are dropped; x0 always reads 0.
//  - Reads: combinational, 0-cycle latency.
//    - rsN_addr==0                         -> 0.
//    - else wb_en && rsN_addr==wb_rd       -> wb_data (write-through bypass).
//    - else                                -> regs[rsN_addr].
//    - Both ports may bypass in the same cycle.
//  - Trace: registered 1-cycle copy of the commit.
//    - trace_valid <= wb_en; trace_rd <= wb_rd; trace_data <= wb_data.
//    - When wb_en=0, trace_rd and trace_data hold their previous values.
//  - Counters:
//    - cycle_count += 1 every non-reset cycle.
//    - wr_count += 1 on each cycle with wb_en=1.
//    - Both wrap modulo 2^CNT_W with no saturation and no flag.
//  - Reset (synchronous, any cycle including mid-stream):
//    - All NUM_REGS registers clear to 0.
//    - trace_valid/rd/data clear to 0; cycle_count and wr_count clear to 0.
//    - A write presented in the reset cycle is discarded, and the trace does not show it.
//    - The first counted cycle is the first posedge with reset=0; cycle_count reads 1 after it.
//  - Combinational outputs (wb_*, rsN_data) follow inputs during reset.
//    - Register contents read 0 after the reset edge.
//  - No handshake or stall: MEM/WB advances every cycle, so this stage never back-pressures.
// STRUCTURE
//  - writeback_pkg holds:
//    - REG_ADDR_W=5, NUM_REGS, XLEN, CNT_W.
//    - typedef wb_trace_t {valid, rd, data}.
//    - function wb_select(mem_wb_t) returning XLEN.
//  - One sub-module, regfile_2r1w:
//    - Storage, synchronous clear, x0 masking, bypass muxes.
//    - Ports: clk, reset, we, waddr, wdata, raddr1/2, rdata1/2.
//  - The top holds the result mux, the trace register and the counters.
// TESTING
//  1. Reset then idle: hold mem_wb='0 for 10 cycles.
//     -> rs1/rs2 read 0 for all addrs; wr_count=0; cycle_count=10; trace_valid=0.
//  2. ALU write then load write:
//     - ALU write: {rd=5, RegWrite=1, MemToReg=0, alu_result=32'h1234_5678}.
//     - Next cycle, load: {rd=6, MemToReg=1, mem_data=32'hDEAD_BEEF}.
//     -> x5=12345678, x6=DEADBEEF; trace shows each one cycle later; wr_count=2.
//  3. Bypass: in the same cycle, write x7=32'hCAFE_0001 with rs1_addr=7 and rs2_addr=7.
//     -> both ports return CAFE0001 combinationally in that cycle, and from the register file next cycle.
//  4. x0 and bubbles: RegWrite=1 with rd=0 and alu_result=32'hFFFF_FFFF, then RegWrite=0 with rd=9.
//     -> x0 reads 0; x9 unchanged; wb_en=0 both cycles; wr_count unchanged; trace_valid=0.
//  5. Reset mid-stream: fill x1..x31 with 32'hA5A5_0000+i, then assert reset for 1 cycle while a write to x3 is presented.
//     -> all regs read 0; counters 0; trace_valid=0; x3 is not written.
//  6. Counter wrap: compile with CNT_W=4 and run 17 non-reset cycles with writes every cycle.
//     -> cycle_count=1 and wr_count=1 after wrap; no other side effects.

Source files
------------

// File: rtl/memory_pkg.sv
// MEM/WB pipeline register payload shared between the memory and writeback stages.
package memory_pkg;

   localparam int unsigned MEM_XLEN   = 32;
   localparam int unsigned MEM_ADDR_W = 5;

   typedef struct packed {
      logic [MEM_XLEN-1:0]   mem_data;
      logic [MEM_XLEN-1:0]   alu_result;
      logic [MEM_ADDR_W-1:0] rd;
      logic                  RegWrite;
      logic                  MemToReg;
   } mem_wb_t;

endpackage

// File: rtl/writeback_pkg.sv
// Writeback-stage widths, commit trace record and the result-select helper.
package writeback_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned CNT_W      = 64;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_trace_t;

   // Load data wins over the ALU result when the instruction was a load.
   function automatic logic [XLEN-1:0] wb_select(input memory_pkg::mem_wb_t m);
      return m.MemToReg ? XLEN'(m.mem_data) : XLEN'(m.alu_result);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports with write-through bypass, one write port.
module regfile_2r1w
   import writeback_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2
);

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] regs_d [NUM_REGS];
   logic            wr_ok;

   // x0 is never stored, so a write aimed at it is simply dropped.
   assign wr_ok = we && (waddr != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass lets ID see a value in the same cycle it is being written.
   always_comb begin
      rdata1 = regs_q[raddr1];
      if (wr_ok && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
      if (raddr1 == '0) begin
         rdata1 = '0;
      end
   end

   always_comb begin
      rdata2 = regs_q[raddr2];
      if (wr_ok && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
      if (raddr2 == '0) begin
         rdata2 = '0;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: result select, register file ownership, commit trace and perf counters.
module writeback_stage
   import writeback_pkg::*;
#(
   parameter int unsigned CNT_W = writeback_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  memory_pkg::mem_wb_t   mem_wb,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic                  trace_valid,
   output logic [REG_ADDR_W-1:0] trace_rd,
   output logic [XLEN-1:0]       trace_data,
   output logic [CNT_W-1:0]      cycle_count,
   output logic [CNT_W-1:0]      wr_count
);

   wb_trace_t        trace_d,       trace_q;
   logic [CNT_W-1:0] cycle_count_d, cycle_count_q;
   logic [CNT_W-1:0] wr_count_d,    wr_count_q;

   // A bubble (all-zero payload) has RegWrite=0 and therefore never commits.
   assign wb_data = wb_select(mem_wb);
   assign wb_rd   = REG_ADDR_W'(mem_wb.rd);
   assign wb_en   = mem_wb.RegWrite && (mem_wb.rd != '0);

   regfile_2r1w u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data)
   );

   // Trace rd/data hold their last committed values across idle cycles.
   always_comb begin
      trace_d       = trace_q;
      cycle_count_d = cycle_count_q + CNT_W'(1);
      wr_count_d    = wr_count_q;
      trace_d.valid = wb_en;
      if (wb_en) begin
         trace_d.rd   = wb_rd;
         trace_d.data = wb_data;
         wr_count_d   = wr_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trace_q       <= '0;
         cycle_count_q <= '0;
         wr_count_q    <= '0;
      end else begin
         trace_q       <= trace_d;
         cycle_count_q <= cycle_count_d;
         wr_count_q    <= wr_count_d;
      end
   end

   assign trace_valid = trace_q.valid;
   assign trace_rd    = trace_q.rd;
   assign trace_data  = trace_q.data;
   assign cycle_count = cycle_count_q;
   assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage, with a 4-bit-counter instance exercising counter wrap.
module tb_writeback_stage;

   typedef memory_pkg::mem_wb_t mw_t;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        en;
      logic [4:0]  rd;
      logic [31:0] wbd;
      logic        tv;
      logic [4:0]  trd;
      logic [31:0] tdata;
      logic [63:0] cyc;
      logic [63:0] wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   mw_t         mem_wb;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data, trace_data;
   logic        wb_en, trace_valid;
   logic [4:0]  wb_rd, trace_rd;
   logic [63:0] cycle_count, wr_count;

   logic [31:0] s_rs1_data, s_rs2_data, s_wb_data, s_trace_data;
   logic        s_wb_en, s_trace_valid;
   logic [4:0]  s_wb_rd, s_trace_rd;
   logic [3:0]  s_cycle_count, s_wr_count;

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];

   // Reference state: architectural registers, last commit, event counts.
   logic [31:0] m_regs [32];
   logic        m_tv;
   logic [4:0]  m_trd;
   logic [31:0] m_tdata;
   logic [63:0] m_cyc, m_wr;
   mw_t         prev_mw;
   logic        prev_rst;

   always #5 clk = ~clk;

   writeback_stage dut (
      .clk(clk), .reset(reset), .mem_wb(mem_wb),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data),
      .cycle_count(cycle_count), .wr_count(wr_count)
   );

   writeback_stage #(.CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .mem_wb(mem_wb),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
      .wb_en(s_wb_en), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
      .trace_valid(s_trace_valid), .trace_rd(s_trace_rd), .trace_data(s_trace_data),
      .cycle_count(s_cycle_count), .wr_count(s_wr_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   function automatic mw_t mk(input logic [4:0] rd, input logic rw, input logic m2r,
                              input logic [31:0] alu, input logic [31:0] mem);
      mw_t m;
      m.rd = rd; m.RegWrite = rw; m.MemToReg = m2r;
      m.alu_result = alu; m.mem_data = mem;
      return m;
   endfunction

   function automatic logic [31:0] value_of(input mw_t m);
      return m.MemToReg ? m.mem_data : m.alu_result;
   endfunction

   function automatic logic commits(input mw_t m);
      return m.RegWrite && (m.rd != 5'd0);
   endfunction

   function automatic logic [31:0] read_exp(input logic [4:0] a, input mw_t m);
      if (a == 5'd0) return 32'd0;
      if (commits(m) && a == m.rd) return value_of(m);
      return m_regs[a];
   endfunction

   // Advance the reference by the clock edge that consumed the previous cycle's inputs.
   task automatic model_edge();
      if (prev_rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_tv = 1'b0; m_trd = 5'd0; m_tdata = 32'd0; m_cyc = 64'd0; m_wr = 64'd0;
      end else begin
         m_cyc = m_cyc + 64'd1;
         m_tv  = commits(prev_mw);
         if (m_tv) begin
            m_regs[prev_mw.rd] = value_of(prev_mw);
            m_trd   = prev_mw.rd;
            m_tdata = value_of(prev_mw);
            m_wr    = m_wr + 64'd1;
         end
      end
   endtask

   task automatic step(input mw_t m, input logic r, input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      mem_wb = m; reset = r; rs1_addr = a1; rs2_addr = a2;
      prev_mw = m; prev_rst = r;
      e.rs1 = read_exp(a1, m);
      e.rs2 = read_exp(a2, m);
      e.en  = commits(m);
      e.rd  = m.rd;
      e.wbd = value_of(m);
      e.tv  = m_tv; e.trd = m_trd; e.tdata = m_tdata;
      e.cyc = m_cyc; e.wr = m_wr;
      exp_q.push_back(e);
   endtask

   // Monitor: every mid-cycle sample is checked against the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rs1_data",    64'(rs1_data),    64'(e.rs1));
         chk("rs2_data",    64'(rs2_data),    64'(e.rs2));
         chk("wb_en",       64'(wb_en),       64'(e.en));
         chk("wb_rd",       64'(wb_rd),       64'(e.rd));
         chk("wb_data",     64'(wb_data),     64'(e.wbd));
         chk("trace_valid", 64'(trace_valid), 64'(e.tv));
         chk("trace_rd",    64'(trace_rd),    64'(e.trd));
         chk("trace_data",  64'(trace_data),  64'(e.tdata));
         chk("cycle_count", cycle_count,      e.cyc);
         chk("wr_count",    wr_count,         e.wr);
         chk("cycle_count_w4", 64'(s_cycle_count), 64'(e.cyc[3:0]));
         chk("wr_count_w4",    64'(s_wr_count),    64'(e.wr[3:0]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mw_t         idle;
      mw_t         m;
      logic [4:0]  a1, a2;
      idle     = '0;
      mem_wb   = '0;
      reset    = 1'b1;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      prev_mw  = '0;
      prev_rst = 1'b1;

      // Reset, then idle bubbles with reads sweeping the file.
      step(idle, 1'b1, 5'd0, 5'd0);
      step(idle, 1'b1, 5'd1, 5'd2);
      for (int i = 0; i < 11; i++) step(idle, 1'b0, 5'(3 * i), 5'(31 - 2 * i));

      // ALU write then load write, each visible one cycle later in the trace.
      step(mk(5'd5, 1'b1, 1'b0, 32'h1234_5678, $urandom), 1'b0, 5'd5, 5'd0);
      step(mk(5'd6, 1'b1, 1'b1, $urandom, 32'hDEAD_BEEF), 1'b0, 5'd5, 5'd6);
      step(idle, 1'b0, 5'd5, 5'd6);

      // Both ports bypass a write in flight, then read it from storage.
      step(mk(5'd7, 1'b1, 1'b0, 32'hCAFE_0001, $urandom), 1'b0, 5'd7, 5'd7);
      step(idle, 1'b0, 5'd7, 5'd7);

      // Write to x0 and a RegWrite=0 slot targeting x9 must both be ignored.
      step(mk(5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, $urandom), 1'b0, 5'd0, 5'd9);
      step(mk(5'd9, 1'b0, 1'b0, 32'h0BAD_0BAD, $urandom), 1'b0, 5'd9, 5'd0);
      step(idle, 1'b0, 5'd9, 5'd0);

      // Fill the file, then reset mid-stream while a write to x3 is presented.
      for (int i = 1; i < 32; i++)
         step(mk(5'(i), 1'b1, 1'b0, 32'hA5A5_0000 + 32'(i), $urandom), 1'b0, 5'(i), 5'(i - 1));
      step(mk(5'd3, 1'b1, 1'b0, 32'h3333_3333, $urandom), 1'b1, 5'd3, 5'd4);
      for (int i = 0; i < 32; i++) step(idle, 1'b0, 5'(i), 5'(31 - i));

      // Long random stream; the 4-bit instance wraps its counters repeatedly.
      for (int n = 0; n < 300; n++) begin
         m = mk(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 1'($urandom),
                $urandom, $urandom);
         a1 = ($urandom_range(0, 2) == 0) ? m.rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? m.rd : 5'($urandom_range(0, 7));
         step(m, ($urandom_range(0, 49) == 0), a1, a2);
      end
      step(idle, 1'b0, 5'd1, 5'd2);

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
